// File: rtl/delay_line.sv
// Multi-stage register delay line with per-stage valid bits, stall, flush
// and a runtime-selectable output tap (latency 1..DEPTH).
// Optional feature: define DELAY_LINE_OCC_EN to add the registered `occ`
// port, which counts the valid stages.
module delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SELW  = 3,
  parameter int unsigned CNTW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SELW-1:0]  sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
`ifdef DELAY_LINE_OCC_EN
  ,
  output logic [CNTW-1:0]  occ
`endif
);

  // Stage 0 is the stage nearest the input.
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [SELW-1:0]  tap;

  // Stage storage: reset beats flush, flush beats advance, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      v <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d[i] <= '0;
      end
    end else if (en) begin
      v[0] <= in_valid;
      d[0] <= in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  end

  // Tap index: a zero or out-of-range sel selects the last stage.
  always_comb begin
    tap = SELW'(DEPTH - 1);
    if (DEPTH > 1) begin
      if ((sel != '0) && (sel <= SELW'(DEPTH))) begin
        tap = sel - SELW'(1);
      end
    end
  end

  // Output mux. It reads the stage registers directly and has no output register.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (SELW'(i) == tap) begin
        out_valid = v[i];
        out_data  = d[i];
      end
    end
  end

`ifdef DELAY_LINE_OCC_EN
  // Occupancy: add the beat entering and subtract the beat leaving stage DEPTH-1.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ <= '0;
    end else if (en) begin
      occ <= occ + CNTW'(in_valid) - CNTW'(v[DEPTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_delay_line.sv
// Directed bench for delay_line (WIDTH=8, DEPTH=4). When DELAY_LINE_OCC_EN is
// defined, it also checks the occ port.
module tb_delay_line;

  logic       clk;
  logic       reset;
  logic       en;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic [2:0] sel;
  logic       out_valid;
  logic [7:0] out_data;
`ifdef DELAY_LINE_OCC_EN
  logic [2:0] occ;
`endif

  int errors = 0;
  int checks = 0;

  delay_line #(.WIDTH(8), .DEPTH(4), .SELW(3), .CNTW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data)
`ifdef DELAY_LINE_OCC_EN
    ,
    .occ      (occ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then settle so that samples are taken away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_data = 8'hFF; sel = 3'd4;
    step();
    step();
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    for (int s = 1; s <= 4; s++) begin
      sel = 3'(s);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
        errors++;
        $display("FAIL reset sel=%0d got v=%b d=%h exp v=0 d=00", s, out_valid, out_data);
      end
    end
`ifdef DELAY_LINE_OCC_EN
    checks++;
    if (occ !== 3'd0) begin
      errors++;
      $display("FAIL reset_occ got %0d exp 0", occ);
    end
`endif
  endtask

  task automatic test_latency(input logic [2:0] s, input int k);
    logic exp_v;
    do_flush();
    sel = s; en = 1'b1;
    in_valid = 1'b1; in_data = 8'hA5;
    for (int j = 1; j <= 6; j++) begin
      step();
      in_valid = 1'b0; in_data = 8'h00;
      exp_v = (j == k);
      checks++;
      if (out_valid !== exp_v || (exp_v && out_data !== 8'hA5)) begin
        errors++;
        $display("FAIL latency sel=%0d edge=%0d got v=%b d=%h exp v=%b d=a5",
                 s, j, out_valid, out_data, exp_v);
      end
    end
  endtask

  task automatic test_stall();
    logic exp_v;
    do_flush();
    sel = 3'd4; en = 1'b1;
    in_valid = 1'b1; in_data = 8'h3C;
    for (int j = 1; j <= 8; j++) begin
      step();
      in_valid = 1'b0; in_data = 8'h00;
      if (j >= 2 && j <= 4) en = 1'b0;
      else en = 1'b1;
      exp_v = (j == 7);
      checks++;
      if (out_valid !== exp_v || (exp_v && out_data !== 8'h3C)) begin
        errors++;
        $display("FAIL stall edge=%0d got v=%b d=%h exp v=%b d=3c", j, out_valid, out_data, exp_v);
      end
      // Edges 3..5 are stalled. During them the beat holds in stage 1, so tap 2 sees it.
      if (j >= 2 && j <= 5) begin
        sel = 3'd2;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
          errors++;
          $display("FAIL stall_hold edge=%0d got v=%b d=%h exp v=1 d=3c", j, out_valid, out_data);
        end
        sel = 3'd4;
        #1;
      end
    end
  endtask

  task automatic test_flush();
    do_flush();
    sel = 3'd4; en = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      in_valid = 1'b1; in_data = 8'(8'h11 * j);
      step();
    end
`ifdef DELAY_LINE_OCC_EN
    checks++;
    if (occ !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre_occ got %0d exp 3", occ);
    end
`endif
    in_valid = 1'b1; in_data = 8'h44; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
`ifdef DELAY_LINE_OCC_EN
    checks++;
    if (occ !== 3'd0) begin
      errors++;
      $display("FAIL flush_occ got %0d exp 0", occ);
    end
`endif
    for (int s = 0; s <= 7; s++) begin
      sel = 3'(s);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
        errors++;
        $display("FAIL flush_clear sel=%0d got v=%b d=%h exp v=0 d=00", s, out_valid, out_data);
      end
    end
    sel = 3'd4;
    for (int j = 1; j <= 5; j++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
        errors++;
        $display("FAIL flush_drop edge=%0d got v=%b d=%h exp v=0 d=00", j, out_valid, out_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       exp_v;
    logic [7:0] exp_d;
    int         exp_occ;
    do_flush();
    sel = 3'd4; en = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      in_valid = (j <= 8);
      in_data  = (j <= 8) ? 8'(j) : 8'h00;
      step();
      exp_v = (j >= 4 && j <= 11);
      exp_d = 8'(j - 3);
      checks++;
      if (out_valid !== exp_v || (exp_v && out_data !== exp_d)) begin
        errors++;
        $display("FAIL stream edge=%0d got v=%b d=%h exp v=%b d=%h",
                 j, out_valid, out_data, exp_v, exp_d);
      end
      // The stages hold the beats sent at edges j-3..j. Count those that fall in 1..8.
      exp_occ = 0;
      for (int b = j - 3; b <= j; b++) begin
        if (b >= 1 && b <= 8) exp_occ++;
      end
`ifdef DELAY_LINE_OCC_EN
      checks++;
      if (occ !== 3'(exp_occ)) begin
        errors++;
        $display("FAIL stream_occ edge=%0d got %0d exp %0d", j, occ, exp_occ);
      end
`endif
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_flush();
    sel = 3'd4; en = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      in_valid = 1'b1; in_data = 8'(8'h70 + j);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    for (int j = 1; j <= 4; j++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid edge=%0d got v=%b d=%h exp v=0", j, out_valid, out_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency(3'd4, 4);
    test_latency(3'd1, 1);
    test_latency(3'd2, 2);
    test_latency(3'd0, 4);
    test_latency(3'd7, 4);
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
